// File: rtl/display_scanout_pkg.sv
// Shared types, video modes and scan-out geometry helpers for the display scan-out slice.
// The geometry functions are evaluated at elaboration time from the mode and buffer parameters.
package display_scanout_pkg;

  typedef logic [15:0] coord_t;
  typedef logic [11:0] color_t;
  typedef logic [3:0]  color_ch_t;
  typedef logic [1:0]  fb_sel_t;

  typedef struct packed {
    coord_t h_res;
    coord_t h_fp;
    coord_t h_sync;
    coord_t h_bp;
    coord_t v_res;
    coord_t v_fp;
    coord_t v_sync;
    coord_t v_bp;
    logic   h_pol;   // 1: sync pulse is high while active
    logic   v_pol;
  } video_mode_t;

  typedef struct packed {
    coord_t     width;
    coord_t     height;
    logic [4:0] addr_width;
  } buffer_config_t;

  // Timing decode carried down the delay pipe alongside the framebuffer read
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
  } pipe_t;

  localparam video_mode_t VMODE_640x480p60 = '{
    h_res: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_res: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    h_pol: 1'b0,    v_pol: 1'b0
  };

  localparam buffer_config_t BUFFER_160x120x12 = '{
    width: 16'd160, height: 16'd120, addr_width: 5'd15
  };

  function automatic int line_width(video_mode_t m);
    return int'(m.h_res) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
  endfunction

  function automatic int line_height(video_mode_t m);
    return int'(m.v_res) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
  endfunction

  // Largest power-of-two magnification that still fits both axes
  function automatic int calc_scale(video_mode_t m, buffer_config_t b);
    int rx;
    int ry;
    int r;
    int s;
    rx = (b.width  == 16'd0) ? 0 : int'(m.h_res) / int'(b.width);
    ry = (b.height == 16'd0) ? 0 : int'(m.v_res) / int'(b.height);
    r  = (rx < ry) ? rx : ry;
    s  = 0;
    for (int i = 1; i < 16; i++) begin
      if ((1 << i) <= r) s = i;
    end
    return s;
  endfunction

  function automatic int img_w_of(video_mode_t m, buffer_config_t b);
    return int'(b.width) << calc_scale(m, b);
  endfunction

  function automatic int img_h_of(video_mode_t m, buffer_config_t b);
    return int'(b.height) << calc_scale(m, b);
  endfunction

  function automatic int x0_of(video_mode_t m, buffer_config_t b);
    return (int'(m.h_res) - img_w_of(m, b)) / 2;
  endfunction

  function automatic int y0_of(video_mode_t m, buffer_config_t b);
    return (int'(m.v_res) - img_h_of(m, b)) / 2;
  endfunction

endpackage

// File: rtl/display_scanout_if.sv
// Framebuffer read port plus the renderer's buffer-swap handshake.
// The scan-out engine is the master; framebuffer/renderer side is the slave.
interface display_scanout_if
  import display_scanout_pkg::*;
#(
  parameter int ADDR_W = 15
);
  logic              swap_req;
  logic              swap_ack;
  fb_sel_t           front_buffer;
  fb_sel_t           read_buf_sel;
  logic [ADDR_W-1:0] read_addr;
  logic              read_en;
  color_t            read_data;

  modport master (
    input  swap_req, read_data,
    output swap_ack, front_buffer, read_buf_sel, read_addr, read_en
  );

  modport slave (
    output swap_req, read_data,
    input  swap_ack, front_buffer, read_buf_sel, read_addr, read_en
  );
endinterface

// File: rtl/display_scanout_timing.sv
// Raster x/y counters with combinational sync/active decode and a registered
// frame_start pulse coinciding with the counters sitting at (0,0).
module display_scanout_timing
  import display_scanout_pkg::*;
#(
  parameter video_mode_t VIDEO_MODE = VMODE_640x480p60
) (
  input  logic   clk_pixel,
  input  logic   rstn_pixel,
  output coord_t o_x,
  output coord_t o_y,
  output logic   o_hsync_act,
  output logic   o_vsync_act,
  output logic   o_active,
  output logic   o_last,
  output logic   o_frame_start
);
  localparam coord_t LW_M1    = coord_t'(line_width(VIDEO_MODE) - 1);
  localparam coord_t LH_M1    = coord_t'(line_height(VIDEO_MODE) - 1);
  localparam coord_t HS_START = VIDEO_MODE.h_res + VIDEO_MODE.h_fp;
  localparam coord_t HS_END   = HS_START + VIDEO_MODE.h_sync;
  localparam coord_t VS_START = VIDEO_MODE.v_res + VIDEO_MODE.v_fp;
  localparam coord_t VS_END   = VS_START + VIDEO_MODE.v_sync;

  coord_t r_x;
  coord_t r_y;
  logic   r_frame_start;
  logic   w_last;

  assign w_last = (r_x == LW_M1) && (r_y == LH_M1);

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_last;
      if (r_x == LW_M1) begin
        r_x <= '0;
        r_y <= (r_y == LH_M1) ? '0 : r_y + 16'd1;
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_last        = w_last;
  assign o_frame_start = r_frame_start;
  assign o_hsync_act   = (r_x >= HS_START) && (r_x < HS_END);
  assign o_vsync_act   = (r_y >= VS_START) && (r_y < VS_END);
  assign o_active      = (r_x < VIDEO_MODE.h_res) && (r_y < VIDEO_MODE.v_res);
endmodule

// File: rtl/display_scanout.sv
// Scan-out engine: integer-scaled, centred framebuffer fetch with border fill and
// a fixed READ_LATENCY+2 counter-to-pin latency for syncs, data enable and colour.
module display_scanout
  import display_scanout_pkg::*;
#(
  parameter video_mode_t    VIDEO_MODE      = VMODE_640x480p60,
  parameter buffer_config_t BUFFER_CONFIG   = BUFFER_160x120x12,
  parameter int             READ_LATENCY    = 1,
  parameter int             NUM_BUFFERS     = 2,
  parameter color_t         BORDER_COLOR    = 12'h000,
  parameter bit             FLIP_HORIZONTAL = 1'b0,
  parameter bit             FLIP_VERTICAL   = 1'b0
) (
  input  logic              clk_pixel,
  input  logic              rstn_pixel,
  display_scanout_if.master fb,
  output logic              frame_start,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              screen_data_enable,
  output color_ch_t         vga_red,
  output color_ch_t         vga_green,
  output color_ch_t         vga_blue
);
  localparam int          AW     = int'(BUFFER_CONFIG.addr_width);
  localparam int          SCALE  = calc_scale(VIDEO_MODE, BUFFER_CONFIG);
  localparam int          IMG_WI = img_w_of(VIDEO_MODE, BUFFER_CONFIG);
  localparam int          IMG_HI = img_h_of(VIDEO_MODE, BUFFER_CONFIG);
  localparam logic [31:0] IMG_W  = 32'(IMG_WI);
  localparam logic [31:0] IMG_H  = 32'(IMG_HI);
  localparam logic [31:0] X0     = 32'(x0_of(VIDEO_MODE, BUFFER_CONFIG));
  localparam logic [31:0] Y0     = 32'(y0_of(VIDEO_MODE, BUFFER_CONFIG));
  localparam logic [31:0] BUF_W  = 32'(BUFFER_CONFIG.width);
  localparam int          DEPTH  = READ_LATENCY + 1;

  generate
    if (IMG_WI > int'(VIDEO_MODE.h_res) || IMG_HI > int'(VIDEO_MODE.v_res) ||
        READ_LATENCY < 1 || READ_LATENCY > 4 || NUM_BUFFERS < 1 || NUM_BUFFERS > 4) begin : g_illegal
      $error("display_scanout: illegal video mode / buffer configuration");
    end
  endgenerate

  coord_t w_x;
  coord_t w_y;
  logic   w_hs;
  logic   w_vs;
  logic   w_active;
  logic   w_last;

  display_scanout_timing #(.VIDEO_MODE(VIDEO_MODE)) u_timing (
    .clk_pixel     (clk_pixel),
    .rstn_pixel    (rstn_pixel),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_hsync_act   (w_hs),
    .o_vsync_act   (w_vs),
    .o_active      (w_active),
    .o_last        (w_last),
    .o_frame_start (frame_start)
  );

  // Window-relative coordinates; out-of-window values wrap but are masked by w_win
  logic [31:0] w_x32;
  logic [31:0] w_y32;
  logic [31:0] w_rx;
  logic [31:0] w_ry;
  logic [31:0] w_ix;
  logic [31:0] w_iy;
  logic        w_win;
  pipe_t       w_stage;

  always_comb begin
    w_x32   = {16'd0, w_x};
    w_y32   = {16'd0, w_y};
    w_rx    = w_x32 - X0;
    w_ry    = w_y32 - Y0;
    w_win   = w_active && (w_x32 >= X0) && (w_rx < IMG_W) && (w_y32 >= Y0) && (w_ry < IMG_H);
    w_ix    = FLIP_HORIZONTAL ? (IMG_W - 32'd1 - w_rx) : w_rx;
    w_iy    = FLIP_VERTICAL   ? (IMG_H - 32'd1 - w_ry) : w_ry;
    w_stage = '{hs: w_hs, vs: w_vs, de: w_active, win: w_win};
  end

  logic [AW-1:0] r_read_addr;
  logic          r_read_en;

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      r_read_addr <= '0;
      r_read_en   <= 1'b0;
    end else begin
      r_read_addr <= w_win ? AW'(((w_iy >> SCALE) * BUF_W) + (w_ix >> SCALE)) : '0;
      r_read_en   <= w_win;
    end
  end

  // Timing decode rides a shift register so it lands at the output register with read_data
  pipe_t r_pipe [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
          if (!rstn_pixel) r_pipe[0] <= '0;
          else             r_pipe[0] <= w_stage;
        end
      end else begin : g_tail
        always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
          if (!rstn_pixel) r_pipe[gi] <= '0;
          else             r_pipe[gi] <= r_pipe[gi-1];
        end
      end
    end
  endgenerate

  pipe_t  w_tap;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_de;
  color_t r_color;

  assign w_tap = r_pipe[DEPTH-1];

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      r_hsync <= ~VIDEO_MODE.h_pol;
      r_vsync <= ~VIDEO_MODE.v_pol;
      r_de    <= 1'b0;
      r_color <= '0;
    end else begin
      r_hsync <= w_tap.hs ? VIDEO_MODE.h_pol : ~VIDEO_MODE.h_pol;
      r_vsync <= w_tap.vs ? VIDEO_MODE.v_pol : ~VIDEO_MODE.v_pol;
      r_de    <= w_tap.de;
      r_color <= w_tap.win ? fb.read_data : (w_tap.de ? BORDER_COLOR : '0);
    end
  end

  // Swap is decided on the last raster cycle so the new buffer is live from (0,0)
  fb_sel_t r_front;
  logic    r_swap_ack;

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      r_front    <= '0;
      r_swap_ack <= 1'b0;
    end else begin
      r_swap_ack <= w_last && fb.swap_req;
      if (w_last && fb.swap_req) begin
        r_front <= (r_front == fb_sel_t'(NUM_BUFFERS - 1)) ? '0 : r_front + 2'd1;
      end
    end
  end

  assign fb.read_addr        = r_read_addr;
  assign fb.read_en          = r_read_en;
  assign fb.front_buffer     = r_front;
  assign fb.read_buf_sel     = r_front;
  assign fb.swap_ack         = r_swap_ack;
  assign vga_hsync           = r_hsync;
  assign vga_vsync           = r_vsync;
  assign screen_data_enable  = r_de;
  assign vga_red             = r_color[11:8];
  assign vga_green           = r_color[7:4];
  assign vga_blue            = r_color[3:0];
endmodule

// File: tb/tb_display_scanout.sv
// Directed bench: a 640x480 instance plus two small-raster instances (scaled/bordered
// RL=3 triple-buffer, and flipped single-buffer) sharing one clock and reset.
module tb_display_scanout;
  import display_scanout_pkg::*;

  // 40x20 raster, 32x16 active, positive syncs: hsync x in [34,38), vsync y in [17,19)
  localparam video_mode_t VMODE_TINY = '{
    h_res: 16'd32, h_fp: 16'd2, h_sync: 16'd4, h_bp: 16'd2,
    v_res: 16'd16, v_fp: 16'd1, v_sync: 16'd2, v_bp: 16'd1,
    h_pol: 1'b1,   v_pol: 1'b1
  };
  // 12x6 buffer on 32x16: SCALE=1, image 24x12, X0=4, Y0=2
  localparam buffer_config_t BUF_12x6 = '{width: 16'd12, height: 16'd6, addr_width: 5'd7};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  display_scanout_if #(.ADDR_W(15)) bus_a ();
  display_scanout_if #(.ADDR_W(7))  bus_b ();
  display_scanout_if #(.ADDR_W(7))  bus_c ();

  logic fs_a, hs_a, vs_a, de_a;
  logic fs_b, hs_b, vs_b, de_b;
  logic fs_c, hs_c, vs_c, de_c;
  color_ch_t r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  display_scanout dut_a (
    .clk_pixel(clk), .rstn_pixel(rstn), .fb(bus_a), .frame_start(fs_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .screen_data_enable(de_a),
    .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a)
  );

  display_scanout #(
    .VIDEO_MODE(VMODE_TINY), .BUFFER_CONFIG(BUF_12x6), .READ_LATENCY(3),
    .NUM_BUFFERS(3), .BORDER_COLOR(12'h5A5)
  ) dut_b (
    .clk_pixel(clk), .rstn_pixel(rstn), .fb(bus_b), .frame_start(fs_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b), .screen_data_enable(de_b),
    .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b)
  );

  display_scanout #(
    .VIDEO_MODE(VMODE_TINY), .BUFFER_CONFIG(BUF_12x6), .READ_LATENCY(1),
    .NUM_BUFFERS(1), .FLIP_HORIZONTAL(1'b1), .FLIP_VERTICAL(1'b1)
  ) dut_c (
    .clk_pixel(clk), .rstn_pixel(rstn), .fb(bus_c), .frame_start(fs_c),
    .vga_hsync(hs_c), .vga_vsync(vs_c), .screen_data_enable(de_c),
    .vga_red(r_c), .vga_green(g_c), .vga_blue(b_c)
  );

  // Framebuffer models: A marks address 161, B/C return an address-derived colour
  color_t rd_a;
  color_t rd_b [3];
  color_t rd_c;

  always @(posedge clk) begin
    rd_a    <= (bus_a.read_addr == 15'd161) ? 12'hABC : 12'(bus_a.read_addr);
    rd_b[0] <= 12'(bus_b.read_addr) ^ 12'h800;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
    rd_c    <= 12'(bus_c.read_addr);
  end

  assign bus_a.read_data = rd_a;
  assign bus_b.read_data = rd_b[2];
  assign bus_c.read_data = rd_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cyc equals the raster position the counters held during the cycle being sampled
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    bus_a.swap_req = 1'b0;
    bus_b.swap_req = 1'b0;
    bus_c.swap_req = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_a_hsync", 32'(hs_a), 1);
    chk("rst_a_vsync", 32'(vs_a), 1);
    chk("rst_a_de", 32'(de_a), 0);
    chk("rst_a_read_en", 32'(bus_a.read_en), 0);
    chk("rst_a_frame_start", 32'(fs_a), 0);
    chk("rst_b_hsync", 32'(hs_b), 0);
    chk("rst_b_color", 32'({r_b, g_b, b_b}), 0);
    chk("rst_b_front", 32'(bus_b.front_buffer), 0);

    rstn = 1'b1;
    cyc  = 0;

    goto(51);  chk("b_top_border_read_en", 32'(bus_b.read_en), 0);
    goto(55);  chk("b_top_border_color", 32'({r_b, g_b, b_b}), 'h5A5);
    goto(84);  chk("b_x3_read_en", 32'(bus_b.read_en), 0);
    goto(85);  chk("b_x4_read_en", 32'(bus_b.read_en), 1);
               chk("b_x4_read_addr", 32'(bus_b.read_addr), 0);
               chk("c_flip_first_addr", 32'(bus_c.read_addr), 71);
               chk("c_flip_first_en", 32'(bus_c.read_en), 1);
    goto(88);  chk("b_x3_border_pin", 32'({r_b, g_b, b_b}), 'h5A5);
    goto(89);  chk("b_x4_pixel_pin", 32'({r_b, g_b, b_b}), 'h800);
    goto(236); chk("b_de_x31", 32'(de_b), 1);
    goto(237); chk("b_de_x32", 32'(de_b), 0);
    goto(238); chk("b_hsync_x33", 32'(hs_b), 0);
    goto(239); chk("b_hsync_x34", 32'(hs_b), 1);
    goto(240); chk("b_blank_color", 32'({r_b, g_b, b_b}), 0);
    goto(243); chk("b_hsync_x38", 32'(hs_b), 0);

    goto(300);
    bus_b.swap_req = 1'b1;
    bus_c.swap_req = 1'b1;

    goto(548); chk("b_last_pixel_addr", 32'(bus_b.read_addr), 71);
               chk("b_last_pixel_en", 32'(bus_b.read_en), 1);
               chk("c_flip_last_addr", 32'(bus_c.read_addr), 0);
    goto(549); chk("b_right_border_en", 32'(bus_b.read_en), 0);
    goto(553); chk("b_right_border_pin", 32'({r_b, g_b, b_b}), 'h5A5);
    goto(642); chk("a_de_x639", 32'(de_a), 1);
    goto(643); chk("a_de_x640", 32'(de_a), 0);
    goto(658); chk("a_hsync_x655", 32'(hs_a), 1);
    goto(659); chk("a_hsync_x656", 32'(hs_a), 0);
    goto(684); chk("b_vsync_y16", 32'(vs_b), 0);
    goto(685); chk("b_vsync_y17", 32'(vs_b), 1);
    goto(754); chk("a_hsync_x751", 32'(hs_a), 0);
    goto(755); chk("a_hsync_x752", 32'(hs_a), 1);
    goto(764); chk("b_vsync_y18", 32'(vs_b), 1);
    goto(765); chk("b_vsync_y19", 32'(vs_b), 0);

    goto(799); chk("b_ack_before_frame", 32'(bus_b.swap_ack), 0);
               chk("b_front_before_frame", 32'(bus_b.front_buffer), 0);
               chk("b_fs_before_frame", 32'(fs_b), 0);
    goto(800); chk("b_swap1_ack", 32'(bus_b.swap_ack), 1);
               chk("b_swap1_front", 32'(bus_b.front_buffer), 1);
               chk("b_swap1_sel", 32'(bus_b.read_buf_sel), 1);
               chk("b_frame_start", 32'(fs_b), 1);
               chk("c_single_ack", 32'(bus_c.swap_ack), 1);
               chk("c_single_front", 32'(bus_c.front_buffer), 0);
    bus_b.swap_req = 1'b0;
    bus_c.swap_req = 1'b0;
    goto(801); chk("b_ack_one_cycle", 32'(bus_b.swap_ack), 0);
               chk("b_fs_one_cycle", 32'(fs_b), 0);
    goto(1459); chk("a_hsync_line1", 32'(hs_a), 0);

    goto(1599);
    bus_b.swap_req = 1'b1;
    goto(1600); chk("b_late_req_ack", 32'(bus_b.swap_ack), 1);
                chk("b_late_req_front", 32'(bus_b.front_buffer), 2);
    bus_b.swap_req = 1'b0;
    goto(1700);
    bus_b.swap_req = 1'b1;
    goto(2400); chk("b_wrap_ack", 32'(bus_b.swap_ack), 1);
                chk("b_wrap_front", 32'(bus_b.front_buffer), 0);
    bus_b.swap_req = 1'b0;
    goto(3100);
    bus_b.swap_req = 1'b1;
    goto(3200); chk("b_swap4_front", 32'(bus_b.front_buffer), 1);
    bus_b.swap_req = 1'b0;

    goto(3205); chk("a_addr_4_4", 32'(bus_a.read_addr), 161);
                chk("a_en_4_4", 32'(bus_a.read_en), 1);
    goto(3207); chk("a_pin_4_4", 32'({r_a, g_a, b_a}), 'hABC);
                chk("a_de_4_4", 32'(de_a), 1);

    goto(3210);
    bus_b.swap_req = 1'b1;
    goto(3250);
    rstn = 1'b0;
    #1;
    chk("midrst_b_front", 32'(bus_b.front_buffer), 0);
    chk("midrst_b_ack", 32'(bus_b.swap_ack), 0);
    chk("midrst_b_hsync", 32'(hs_b), 0);
    chk("midrst_b_color", 32'({r_b, g_b, b_b}), 0);
    chk("midrst_a_hsync", 32'(hs_a), 1);
    chk("midrst_a_de", 32'(de_a), 0);
    chk("midrst_a_read_en", 32'(bus_a.read_en), 0);
    chk("midrst_a_read_addr", 32'(bus_a.read_addr), 0);
    bus_b.swap_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_b_ack_held", 32'(bus_b.swap_ack), 0);
    rstn = 1'b1;
    cyc  = 0;

    goto(658); chk("restart_a_hsync_x655", 32'(hs_a), 1);
    goto(659); chk("restart_a_hsync_x656", 32'(hs_a), 0);
    goto(800); chk("restart_b_frame_start", 32'(fs_b), 1);
               chk("restart_b_no_ack", 32'(bus_b.swap_ack), 0);
               chk("restart_b_front", 32'(bus_b.front_buffer), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
